hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline sequencing controller for the five-stage core. It owns every stall and flush enable on the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It arbitrates four hazard sources: data-memory miss, taken branch from exec, load-use dependency and instruction-memory miss. It also keeps a saturating stall-cycle counter.

## Interface
- No parameters.
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- memRead_IDEX  in  1  instruction in EX is a load
- rt_IDEX  in  5  destination of the load in EX
- rs_IFID, rt_IFID  in  5 each  source registers of the instruction in ID
- pcSrc  in  1  taken branch resolved in EX (same-cycle signal from exec)
- dMiss  in  1  MEM-stage access missed; level, held until serviced
- dReady  in  1  data fill complete; 1-cycle pulse
- iMiss  in  1  fetch missed; level
- iReady  in  1  instruction fill complete; 1-cycle pulse
- stallPC, stallIFID, stallIDEX, stallEXMEM  out  1 each  hold the register
- flushIFID, flushIDEX, flushMEMWB  out  1 each  load a bubble; a flush overrides a stall on the same register
- stallCycles  out  16  count of cycles with any stall* asserted; saturates at 0xFFFF
- ctrlState  out  2  current FSM state, for debug

## Operation
- FSM states:
  - RUN=0: normal operation.
  - DWAIT=1: waiting on a data fill.
  - IWAIT=2: waiting on an instruction fill.
  - 3 is unused and recovers to RUN.
- Outputs are combinational from state plus inputs. The state register, dropFetch flag and counter are registered.
- Priority in RUN, highest first:
  1. dMiss: stallPC, stallIFID, stallIDEX, stallEXMEM=1 and flushMEMWB=1. pcSrc and load-use are ignored this cycle. Next state is DWAIT.
  2. pcSrc: flushIFID=1, flushIDEX=1. Load-use and iMiss are suppressed. Stay in RUN.
  3. Load-use: memRead_IDEX && rt_IDEX!=0 && (rt_IDEX==rs_IFID || rt_IDEX==rt_IFID). Drives stallPC=1, stallIFID=1, flushIDEX=1 for one cycle. Stay in RUN. A load-use hazard takes precedence over iMiss in the same cycle; iMiss is re-evaluated the next cycle.
  4. iMiss: stallPC=1, flushIFID=1 and the back end proceeds. Next state is IWAIT.
- DWAIT:
  - Same outputs as priority 1 while dReady=0.
  - On dReady all outputs are 0 in that cycle and the state returns to RUN next cycle.
  - pcSrc and iMiss are ignored; both are re-evaluated in RUN because EX and IF were frozen.
- IWAIT:
  - stallPC=1 and flushIFID=1 each cycle. ID onward runs freely, and load-use is evaluated against the bubble, which yields no match.
  - A dMiss in IWAIT adds stallIDEX, stallEXMEM and flushMEMWB and keeps the state in IWAIT. The dMiss/dReady handshake is then serviced in parallel.
  - A pcSrc in IWAIT drives stallPC=0 for that cycle so PC loads the target, and sets dropFetch.
  - On iReady: if dropFetch=0, stallPC=0 and flushIFID=0, so IF/ID captures the fetched word. If dropFetch=1, flushIFID=1 and the word is discarded. In both cases dropFetch is cleared and the state returns to RUN next cycle.
  - If dMiss is still pending at iReady, the next state is DWAIT instead of RUN.
- Counter: increments when any stall* output is 1, holds at 0xFFFF, and is cleared only by reset.

## Timing
- Reset (synchronous): state=RUN, dropFetch=0, stallCycles=0. With idle inputs every output is 0 in the first cycle after reset.
- Zero-cycle response: every hazard affects outputs in the cycle it is presented.
- Load-use costs exactly 1 bubble.
- A taken branch costs 2 flushed slots.
- A data miss costs N+1 cycles, where N is the number of cycles from the dMiss rise to dReady.
- Back-to-back dMiss at the cycle after dReady re-enters DWAIT with no idle gap.
- dReady or iReady arriving in RUN, with no wait pending, is ignored.
- Reset asserted mid-DWAIT or mid-IWAIT aborts to RUN and clears dropFetch; an outstanding fill pulse afterwards is ignored.

## Structure
- hazard_pkg holds:
  - the state enum (RUN, DWAIT, IWAIT) and the 2-bit state width;
  - the REG_ZERO=5'd0 constant;
  - the COUNTER_MAX=16'hFFFF constant.
- The sub-module loadUseDetect is combinational: inputs memRead_IDEX, rt_IDEX, rs_IFID, rt_IFID; output hazard. It is instantiated once.
- The FSM, output decode and counter live in hazard_ctrl.

## Test plan
- **Load-use.** Present memRead_IDEX=1, rt_IDEX=5, rs_IFID=5 for one cycle. Expect stallPC=stallIFID=flushIDEX=1 for exactly that cycle and stallCycles=1. Repeat with rt_IDEX=0: expect no stall.
- **Taken branch with competing hazards.** In the same cycle present pcSrc=1, load-use true and iMiss=1. Expect flushIFID=flushIDEX=1, stallPC=0, state RUN.
- **Data miss.** Raise dMiss with pcSrc=1; expect DWAIT with all four stalls and flushMEMWB. After 4 cycles pulse dReady. Expect outputs 0 in the dReady cycle, RUN next, and stallCycles=5.
- **Instruction miss with branch.** Raise iMiss; expect IWAIT. Pulse pcSrc at cycle 2; expect stallPC=0 in that cycle. Pulse iReady at cycle 5; expect flushIFID=1 (dropFetch path) and RUN next.
- **Overlapping misses.** In IWAIT, raise dMiss and pulse iReady while dMiss is still held. Expect next state DWAIT. Then pulse dReady; expect RUN.
- **Reset and saturation.** Assert reset mid-DWAIT; expect state=RUN, stallCycles=0 and all outputs 0 next cycle. Separately, hold dMiss for 70000 cycles; expect stallCycles to hold at 0xFFFF.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// hazard_pkg : shared types and constants for the pipeline hazard controller
// Revision   : 1.0
// ============================================================================
package hazard_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    IWAIT = 2'd2
  } ctrl_state_e;

  localparam logic [4:0]  REG_ZERO    = 5'd0;
  localparam logic [15:0] COUNTER_MAX = 16'hFFFF;

  typedef struct packed {
    logic stall_pc;
    logic stall_ifid;
    logic stall_idex;
    logic stall_exmem;
    logic flush_ifid;
    logic flush_idex;
    logic flush_memwb;
  } ctrl_out_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == COUNTER_MAX) ? value : value + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_load_use.sv
`default_nettype none
// ============================================================================
// loadUseDetect : flags a load in EX whose destination feeds the ID instruction
// Revision      : 1.0
// ============================================================================
module loadUseDetect
  import hazard_pkg::*;
(
  input  logic       memRead_IDEX,
  input  logic [4:0] rt_IDEX,
  input  logic [4:0] rs_IFID,
  input  logic [4:0] rt_IFID,
  output logic       hazard
);

  // r0 is hardwired to zero, so a load targeting it never creates a dependency
  assign hazard = memRead_IDEX
               && (rt_IDEX != REG_ZERO)
               && ((rt_IDEX == rs_IFID) || (rt_IDEX == rt_IFID));

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_ctrl : five-stage pipeline stall/flush sequencer and stall counter
// Revision    : 1.0
// ============================================================================
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        memRead_IDEX,
  input  logic [4:0]  rt_IDEX,
  input  logic [4:0]  rs_IFID,
  input  logic [4:0]  rt_IFID,
  input  logic        pcSrc,
  input  logic        dMiss,
  input  logic        dReady,
  input  logic        iMiss,
  input  logic        iReady,
  output logic        stallPC,
  output logic        stallIFID,
  output logic        stallIDEX,
  output logic        stallEXMEM,
  output logic        flushIFID,
  output logic        flushIDEX,
  output logic        flushMEMWB,
  output logic [15:0] stallCycles,
  output logic [1:0]  ctrlState
);

  ctrl_state_e state_q, state_d;
  logic        drop_fetch_q, drop_fetch_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;

  logic        load_use;
  logic        d_pending;
  logic        stall_any;
  ctrl_out_t   out_c;

  loadUseDetect u_load_use (
    .memRead_IDEX (memRead_IDEX),
    .rt_IDEX      (rt_IDEX),
    .rs_IFID      (rs_IFID),
    .rt_IFID      (rt_IFID),
    .hazard       (load_use)
  );

  // A data fill completing this cycle releases the back end immediately
  assign d_pending = dMiss & ~dReady;

  always_comb begin
    out_c        = '0;
    state_d      = state_q;
    drop_fetch_d = drop_fetch_q;

    case (state_q)
      RUN: begin
        if (dMiss) begin
          out_c.stall_pc    = 1'b1;
          out_c.stall_ifid  = 1'b1;
          out_c.stall_idex  = 1'b1;
          out_c.stall_exmem = 1'b1;
          out_c.flush_memwb = 1'b1;
          state_d           = DWAIT;
        end else if (pcSrc) begin
          out_c.flush_ifid = 1'b1;
          out_c.flush_idex = 1'b1;
        end else if (load_use) begin
          out_c.stall_pc   = 1'b1;
          out_c.stall_ifid = 1'b1;
          out_c.flush_idex = 1'b1;
        end else if (iMiss) begin
          out_c.stall_pc   = 1'b1;
          out_c.flush_ifid = 1'b1;
          state_d          = IWAIT;
        end
      end

      DWAIT: begin
        if (dReady) begin
          state_d = RUN;
        end else begin
          out_c.stall_pc    = 1'b1;
          out_c.stall_ifid  = 1'b1;
          out_c.stall_idex  = 1'b1;
          out_c.stall_exmem = 1'b1;
          out_c.flush_memwb = 1'b1;
        end
      end

      IWAIT: begin
        out_c.stall_pc   = 1'b1;
        out_c.flush_ifid = 1'b1;
        if (d_pending) begin
          out_c.stall_idex  = 1'b1;
          out_c.stall_exmem = 1'b1;
          out_c.flush_memwb = 1'b1;
        end
        if (iReady) begin
          // A branch taken while the fill was outstanding makes the word stale
          out_c.stall_pc   = 1'b0;
          out_c.flush_ifid = drop_fetch_q | pcSrc;
          drop_fetch_d     = 1'b0;
          state_d          = d_pending ? DWAIT : RUN;
        end else if (pcSrc) begin
          out_c.stall_pc = 1'b0;
          drop_fetch_d   = 1'b1;
        end
      end

      default: begin
        state_d      = RUN;
        drop_fetch_d = 1'b0;
      end
    endcase
  end

  assign stall_any = out_c.stall_pc | out_c.stall_ifid | out_c.stall_idex | out_c.stall_exmem;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_any) begin
      stall_cycles_d = sat_inc16(stall_cycles_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      drop_fetch_q   <= 1'b0;
      stall_cycles_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      drop_fetch_q   <= drop_fetch_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stallPC     = out_c.stall_pc;
  assign stallIFID   = out_c.stall_ifid;
  assign stallIDEX   = out_c.stall_idex;
  assign stallEXMEM  = out_c.stall_exmem;
  assign flushIFID   = out_c.flush_ifid;
  assign flushIDEX   = out_c.flush_idex;
  assign flushMEMWB  = out_c.flush_memwb;
  assign stallCycles = stall_cycles_q;
  assign ctrlState   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_hazard_ctrl : directed and randomized checks against a rule-level model
// Revision       : 1.0
// ============================================================================
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic [4:0]  rt_ex = '0, rs_id = '0, rt_id = '0;
  logic        pc_src = 1'b0, d_miss = 1'b0, d_ready = 1'b0, i_miss = 1'b0, i_ready = 1'b0;

  logic        stall_pc, stall_ifid, stall_idex, stall_exmem;
  logic        flush_ifid, flush_idex, flush_memwb;
  logic [15:0] stall_cycles;
  logic [1:0]  ctrl_state;

  int checks   = 0;
  int failures = 0;

  // Reference model: which wait is outstanding, whether the pending fetch is stale
  bit m_dwait, m_iwait, m_drop;
  int m_count;

  logic [24:0] obs, exp_v;
  assign obs = {stall_pc, stall_ifid, stall_idex, stall_exmem,
                flush_ifid, flush_idex, flush_memwb, ctrl_state, stall_cycles};

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk          (clk),
    .reset        (rst),
    .memRead_IDEX (mem_read),
    .rt_IDEX      (rt_ex),
    .rs_IFID      (rs_id),
    .rt_IFID      (rt_id),
    .pcSrc        (pc_src),
    .dMiss        (d_miss),
    .dReady       (d_ready),
    .iMiss        (i_miss),
    .iReady       (i_ready),
    .stallPC      (stall_pc),
    .stallIFID    (stall_ifid),
    .stallIDEX    (stall_idex),
    .stallEXMEM   (stall_exmem),
    .flushIFID    (flush_ifid),
    .flushIDEX    (flush_idex),
    .flushMEMWB   (flush_memwb),
    .stallCycles  (stall_cycles),
    .ctrlState    (ctrl_state)
  );

  function automatic bit model_lu();
    return mem_read && (rt_ex != 5'd0) && ((rt_ex == rs_id) || (rt_ex == rt_id));
  endfunction

  // bits: stallPC stallIFID stallIDEX stallEXMEM flushIFID flushIDEX flushMEMWB
  function automatic logic [6:0] model_outs();
    logic [6:0] o;
    o = 7'b0;
    if (m_dwait) begin
      o = d_ready ? 7'b0 : 7'b1111_001;
    end else if (m_iwait) begin
      o[2] = 1'b1;
      o[6] = !pc_src;
      if (i_ready) begin
        o[6] = 1'b0;
        o[2] = m_drop || pc_src;
      end
      if (d_miss && !d_ready) o = o | 7'b0011_001;
    end else if (d_miss) o = 7'b1111_001;
    else if (pc_src)     o = 7'b0000_110;
    else if (model_lu()) o = 7'b1100_010;
    else if (i_miss)     o = 7'b1000_100;
    return o;
  endfunction

  function automatic logic [1:0] model_state();
    return m_dwait ? 2'd1 : (m_iwait ? 2'd2 : 2'd0);
  endfunction

  function automatic logic [24:0] model_expect();
    logic [15:0] c;
    c = m_count[15:0];
    return {model_outs(), model_state(), c};
  endfunction

  // Advance the model with the current inputs, then clock the DUT
  task automatic tick();
    logic [6:0] o;
    o = model_outs();
    if (rst) begin
      m_dwait = 0; m_iwait = 0; m_drop = 0; m_count = 0;
    end else begin
      if (|o[6:3] && m_count < 65535) m_count = m_count + 1;
      if (m_dwait) begin
        if (d_ready) m_dwait = 0;
      end else if (m_iwait) begin
        if (i_ready) begin
          m_iwait = 0;
          m_drop  = 0;
          if (d_miss && !d_ready) m_dwait = 1;
        end else if (pc_src) m_drop = 1;
      end else if (d_miss) m_dwait = 1;
      else if (!pc_src && !model_lu() && i_miss) m_iwait = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    mem_read = 0; rt_ex = 0; rs_id = 0; rt_id = 0;
    pc_src = 0; d_miss = 0; d_ready = 0; i_miss = 0; i_ready = 0;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #3;
    checks++;
    if (obs !== 25'd0) begin
      failures++;
      $display("FAIL reset: got %h want %h", obs, 25'd0);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    mem_read = 1; rt_ex = 5'd5; rs_id = 5'd5;
    #3;
    checks++;
    if (obs !== {7'b1100_010, 2'd0, 16'd0}) begin
      failures++;
      $display("FAIL load_use hit: got %h want %h", obs, {7'b1100_010, 2'd0, 16'd0});
    end
    tick();
    set_idle();
    #3;
    checks++;
    if (obs !== {7'b0, 2'd0, 16'd1}) begin
      failures++;
      $display("FAIL load_use after: got %h want %h", obs, {7'b0, 2'd0, 16'd1});
    end
    tick();
    mem_read = 1; rt_ex = 5'd0; rs_id = 5'd0; rt_id = 5'd0;
    #3;
    checks++;
    if (obs !== {7'b0, 2'd0, 16'd1}) begin
      failures++;
      $display("FAIL load_use r0: got %h want %h", obs, {7'b0, 2'd0, 16'd1});
    end
    tick();
  endtask

  task automatic test_branch_compete();
    do_reset();
    mem_read = 1; rt_ex = 5'd7; rs_id = 5'd7; pc_src = 1; i_miss = 1;
    #3;
    checks++;
    if (obs !== {7'b0000_110, 2'd0, 16'd0}) begin
      failures++;
      $display("FAIL branch_compete: got %h want %h", obs, {7'b0000_110, 2'd0, 16'd0});
    end
    tick();
    set_idle();
    #3;
    checks++;
    if (obs !== 25'd0) begin
      failures++;
      $display("FAIL branch_compete after: got %h want %h", obs, 25'd0);
    end
    tick();
  endtask

  // each table entry: {pcSrc, dMiss, dReady, iMiss, iReady}
  task automatic test_data_miss();
    logic [4:0] seq [0:6];
    seq = '{5'b11000, 5'b01000, 5'b01000, 5'b01000, 5'b01000, 5'b01100, 5'b00000};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      {pc_src, d_miss, d_ready, i_miss, i_ready} = seq[c];
      #3;
      exp_v = model_expect();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL data_miss c%0d: got %h want %h", c, obs, exp_v);
      end
      tick();
    end
    checks++;
    if (stall_cycles !== 16'd5) begin
      failures++;
      $display("FAIL data_miss count: got %0d want 5", stall_cycles);
    end
  endtask

  task automatic test_imiss_branch();
    logic [4:0] seq [0:6];
    seq = '{5'b00010, 5'b00010, 5'b10010, 5'b00010, 5'b00010, 5'b00011, 5'b00000};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      {pc_src, d_miss, d_ready, i_miss, i_ready} = seq[c];
      #3;
      exp_v = model_expect();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL imiss_branch c%0d: got %h want %h", c, obs, exp_v);
      end
      if (c == 5) begin
        checks++;
        if (flush_ifid !== 1'b1 || stall_pc !== 1'b0) begin
          failures++;
          $display("FAIL imiss_drop: got flushIFID=%b stallPC=%b want 1 0", flush_ifid, stall_pc);
        end
      end
      tick();
    end
  endtask

  task automatic test_overlap();
    logic [4:0] seq [0:6];
    seq = '{5'b00010, 5'b00010, 5'b01010, 5'b01011, 5'b01000, 5'b01100, 5'b00000};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      {pc_src, d_miss, d_ready, i_miss, i_ready} = seq[c];
      #3;
      exp_v = model_expect();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL overlap c%0d: got %h want %h", c, obs, exp_v);
      end
      if (c == 4) begin
        checks++;
        if (ctrl_state !== 2'd1) begin
          failures++;
          $display("FAIL overlap dwait: got %0d want 1", ctrl_state);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] seq [0:6];
    seq = '{5'b01000, 5'b01000, 5'b01100, 5'b01000, 5'b01000, 5'b00100, 5'b00000};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      {pc_src, d_miss, d_ready, i_miss, i_ready} = seq[c];
      #3;
      exp_v = model_expect();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL back_to_back c%0d: got %h want %h", c, obs, exp_v);
      end
      if (c == 3) begin
        checks++;
        if (stall_pc !== 1'b1 || ctrl_state !== 2'd0) begin
          failures++;
          $display("FAIL back_to_back gap: got stallPC=%b st=%0d want 1 0", stall_pc, ctrl_state);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    d_miss = 1;
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    set_idle();
    #3;
    checks++;
    if (obs !== 25'd0) begin
      failures++;
      $display("FAIL reset_mid: got %h want %h", obs, 25'd0);
    end
    tick();
    d_ready = 1;
    #3;
    checks++;
    if (obs !== 25'd0) begin
      failures++;
      $display("FAIL reset_mid stray dReady: got %h want %h", obs, 25'd0);
    end
    tick();
    set_idle();
    i_miss = 1;
    tick();
    i_miss = 0;
    pc_src = 1;
    tick();
    pc_src = 0;
    rst = 1;
    tick();
    rst = 0;
    i_ready = 1;
    #3;
    checks++;
    if (obs !== 25'd0) begin
      failures++;
      $display("FAIL reset_mid stray iReady: got %h want %h", obs, 25'd0);
    end
    tick();
    set_idle();
  endtask

  task automatic test_saturation();
    do_reset();
    d_miss = 1;
    repeat (70000) tick();
    #3;
    exp_v = model_expect();
    checks++;
    if (obs !== exp_v || stall_cycles !== 16'hFFFF) begin
      failures++;
      $display("FAIL saturation: got %h want %h (cnt ffff)", obs, exp_v);
    end
    tick();
    #3;
    checks++;
    if (stall_cycles !== 16'hFFFF) begin
      failures++;
      $display("FAIL saturation hold: got %h want ffff", stall_cycles);
    end
    tick();
    set_idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst      = ($urandom_range(0, 63) == 0);
      mem_read = $urandom_range(0, 1);
      rt_ex    = 5'($urandom_range(0, 3));
      rs_id    = 5'($urandom_range(0, 3));
      rt_id    = 5'($urandom_range(0, 3));
      pc_src   = ($urandom_range(0, 3) == 0);
      d_miss   = ($urandom_range(0, 4) == 0);
      d_ready  = ($urandom_range(0, 3) == 0);
      i_miss   = ($urandom_range(0, 3) == 0);
      i_ready  = ($urandom_range(0, 3) == 0);
      #3;
      exp_v = model_expect();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL random c%0d: got %h want %h", c, obs, exp_v);
      end
      tick();
    end
    rst = 0;
    set_idle();
  endtask

  initial begin
    m_dwait = 0; m_iwait = 0; m_drop = 0; m_count = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_branch_compete();
    test_data_miss();
    test_imiss_branch();
    test_overlap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
